// File: rtl/ram_arbiter.sv
// Two-port bounded-burst round-robin arbiter in front of a single-port registered-read RAM.
// Grant is combinational (zero added latency); the losing port is held off by gnt=0 until its turn.
module ram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam int               CNT_W   = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [1:0]       owner;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             sel0;
  logic             sel1;
  logic             burst_open;

  assign burst_open = (cnt < BURST_C);

  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (!reset) begin
      case (owner)
        IDLE: begin
          if (req0 && req1) begin
            sel0 = last;
            sel1 = !last;
          end else begin
            sel0 = req0;
            sel1 = req1;
          end
        end
        OWN0: begin
          // Tenure only ends early when the other port is actually waiting.
          if (req0 && (burst_open || !req1)) sel0 = 1'b1;
          else if (req1)                     sel1 = 1'b1;
        end
        OWN1: begin
          if (req1 && (burst_open || !req0)) sel1 = 1'b1;
          else if (req0)                     sel0 = 1'b1;
        end
        default: begin
          sel0 = 1'b0;
          sel1 = 1'b0;
        end
      endcase
    end
  end

  assign gnt0      = sel0;
  assign gnt1      = sel1;
  assign mem_addr  = sel0 ? addr0  : (sel1 ? addr1  : '0);
  assign mem_wdata = sel0 ? wdata0 : (sel1 ? wdata1 : '0);
  assign mem_load  = (sel0 && we0) || (sel1 && we1);
  assign rdata     = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner   <= IDLE;
      cnt     <= '0;
      last    <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= sel0 && !we0;
      rvalid1 <= sel1 && !we1;
      if (sel0) begin
        last <= 1'b0;
        if (owner == OWN0) begin
          cnt <= (cnt == BURST_C) ? cnt : cnt + ONE_C;
        end else begin
          owner <= OWN0;
          cnt   <= ONE_C;
        end
      end else if (sel1) begin
        last <= 1'b1;
        if (owner == OWN1) begin
          cnt <= (cnt == BURST_C) ? cnt : cnt + ONE_C;
        end else begin
          owner <= OWN1;
          cnt   <= ONE_C;
        end
      end else begin
        owner <= IDLE;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Vector-table bench for ram_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_ram_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int BURST  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_load;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_load(mem_load), .mem_rdata(mem_rdata)
  );

  // Registered-read RAM; never-written words read back as a fixed address pattern.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return {2'b01, a} ^ 16'h5A5A;
  endfunction

  logic                   env_init;
  logic [DATA_W-1:0]      ram [0:(1<<ADDR_W)-1];
  logic [(1<<ADDR_W)-1:0] wr_mask;

  always @(posedge clk) begin
    if (env_init) begin
      wr_mask <= '0;
    end else if (mem_load) begin
      ram[mem_addr]     <= mem_wdata;
      wr_mask[mem_addr] <= 1'b1;
    end
    mem_rdata <= (!env_init && wr_mask[mem_addr]) ? ram[mem_addr] : pat(mem_addr);
  end

  typedef struct {
    logic              rst, r0, r1, w0, w1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;
    logic              g0, g1;
  } vec_t;

  vec_t              vt[$];
  logic [DATA_W-1:0] sb0[$];
  logic [DATA_W-1:0] sb1[$];
  logic [DATA_W-1:0] ref_mem [int];
  int                n_vec = 0;
  int                n_bad = 0;
  logic              exp_rv0 = 1'b0;
  logic              exp_rv1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic rst, r0, r1, w0, w1, input int a0, a1, d0, d1,
                         input logic g0, g1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = ADDR_W'(a0); v.a1 = ADDR_W'(a1);
    v.d0 = DATA_W'(d0); v.d1 = DATA_W'(d1);
    v.g0 = g0; v.g1 = g1;
    vt.push_back(v);
  endtask

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
  endfunction

  task automatic pop_check(input string name, input logic rv, inout logic [DATA_W-1:0] q[$]);
    if (rv === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: rvalid with no read outstanding, rdata %0h", name, rdata);
      end else begin
        check(name, rdata, q.pop_front());
      end
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic              el;
    reset = v.rst; req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
    addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    @(negedge clk);
    ea = v.g0 ? v.a0 : (v.g1 ? v.a1 : '0);
    ed = v.g0 ? v.d0 : (v.g1 ? v.d1 : '0);
    el = (v.g0 && v.w0) || (v.g1 && v.w1);
    check($sformatf("gnt0[%0d]", idx), 32'(gnt0), 32'(v.g0));
    check($sformatf("gnt1[%0d]", idx), 32'(gnt1), 32'(v.g1));
    check($sformatf("both_gnt[%0d]", idx), 32'(gnt0 & gnt1), 32'(0));
    check($sformatf("mem_load[%0d]", idx), 32'(mem_load), 32'(el));
    check($sformatf("mem_addr[%0d]", idx), 32'(mem_addr), 32'(ea));
    check($sformatf("mem_wdata[%0d]", idx), 32'(mem_wdata), 32'(ed));
    check($sformatf("rvalid0[%0d]", idx), 32'(rvalid0), 32'(exp_rv0));
    check($sformatf("rvalid1[%0d]", idx), 32'(rvalid1), 32'(exp_rv1));
    pop_check($sformatf("rdata0[%0d]", idx), rvalid0, sb0);
    pop_check($sformatf("rdata1[%0d]", idx), rvalid1, sb1);
    if (v.g0 && !v.w0) sb0.push_back(ref_rd(v.a0));
    if (v.g1 && !v.w1) sb1.push_back(ref_rd(v.a1));
    if (v.g0 && v.w0) ref_mem[int'(v.a0)] = v.d0;
    if (v.g1 && v.w1) ref_mem[int'(v.a1)] = v.d1;
    exp_rv0 = v.g0 && !v.w0;
    exp_rv1 = v.g1 && !v.w1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with both ports requesting: nothing may be granted.
    for (int i = 0; i < 2; i++) add_vec(1, 1, 1, 0, 0, 10, 20, 0, 0, 0, 0);
    // Continuous contention: bursts of BURST alternate, port 0 first.
    for (int i = 0; i < BURST; i++) add_vec(0, 1, 1, 0, 0, 10, 20, 0, 0, 1, 0);
    for (int i = 0; i < BURST; i++) add_vec(0, 1, 1, 0, 0, 10, 20, 0, 0, 0, 1);
    for (int i = 0; i < BURST; i++) add_vec(0, 1, 1, 0, 0, 10, 20, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Write then read back the same address.
    add_vec(0, 1, 0, 1, 0, 5, 0, 'h1234, 0, 1, 0);
    add_vec(0, 1, 0, 0, 0, 5, 0, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Lone requester saturates, late arrival wins immediately.
    for (int i = 0; i < 10; i++) add_vec(0, 0, 1, 0, 0, 0, 30, 0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 0, 40, 30, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Owner drops mid-tenure; new tenure for port 1 runs a full burst.
    add_vec(0, 1, 0, 0, 0, 41, 0, 0, 0, 1, 0);
    add_vec(0, 1, 1, 0, 1, 41, 7, 0, 'hBEEF, 1, 0);
    add_vec(0, 0, 1, 0, 1, 0, 7, 0, 'hBEEF, 0, 1);
    add_vec(0, 1, 1, 0, 0, 42, 7, 0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 0, 42, 8, 0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 0, 42, 9, 0, 0, 0, 1);
    add_vec(0, 1, 1, 0, 0, 42, 9, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset in the third cycle of a port 1 read burst.
    add_vec(0, 0, 1, 0, 0, 0, 50, 0, 0, 0, 1);
    add_vec(0, 0, 1, 0, 0, 0, 51, 0, 0, 0, 1);
    add_vec(1, 0, 1, 0, 0, 0, 52, 0, 0, 0, 0);
    add_vec(0, 1, 1, 0, 0, 60, 52, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    env_init = 1'b1;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    env_init = 1'b0;

    foreach (vt[i]) apply(vt[i], i);

    check("sb0_drained", 32'(sb0.size()), 32'(0));
    check("sb1_drained", 32'(sb1.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
